// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared state/op types and sizing helper for cache_we_seq
// Revision  : 1.0
// ============================================================================
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    FILL  = 3'd2,
    MERGE = 3'd3,
    DONE  = 3'd4
  } cws_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } cws_op_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int calc_wb(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/component_counter.sv
`default_nettype none
// ============================================================================
// component_counter : up-counter, async active-low clear, sync load + enable
// Revision          : 1.0
// ============================================================================
module component_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority so a counter can be parked at its start value.
  always_comb begin
    count_d = count_q;
    if (load)    count_d = load_val;
    else if (en) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/component_register.sv
`default_nettype none
// ============================================================================
// component_register : enabled register with async active-low clear
// Revision           : 1.0
// ============================================================================
module component_register #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb data_d = en ? d : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= RESET_VAL;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/cache_we_seq.sv
`default_nettype none
// ============================================================================
// cache_we_seq : per-way write-enable sequencer for write hits, line fills
//                and write-allocate merges of an N-way set-associative cache
// Revision     : 1.0
// ============================================================================
module cache_we_seq
  import cache_pkg::*;
#(
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LATENCY    = 2,
  parameter int WRITE_ALLOC    = 1,
  localparam int WB            = calc_wb(WORDS_PER_LINE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re,
  input  logic            we,
  input  logic            hit,
  input  logic [WAYS-1:0] hit_way,
  input  logic [WAYS-1:0] victim_way,
  input  logic [WB-1:0]   word_off,
  output logic [WAYS-1:0] cache_we,
  output logic [WB-1:0]   word_sel,
  output logic            fill_src,
  output logic            mem_re,
  output logic            busy,
  output logic            done
);

  localparam int              WW        = calc_wb(MEM_LATENCY);
  localparam logic [WW-1:0]   WAIT_LAST = WW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
  localparam logic [WB-1:0]   FILL_LAST = WB'(WORDS_PER_LINE - 1);

  cws_state_t        state_q, state_d;
  logic              done_q, done_d;
  logic              arm_q, arm_d;
  logic [WAYS+WB:0]  lat_q;
  logic [WAYS-1:0]   victim_q;
  logic [WB-1:0]     off_q;
  cws_op_t           op_q;
  logic [WW-1:0]     wait_cnt;
  logic [WB-1:0]     fill_cnt;
  logic              accept;

  // rst is folded in so the combinational write-hit path is silent during reset.
  assign accept = (state_q == IDLE) && arm_q && (re || we) && rst;
  assign arm_d  = accept ? 1'b0 : (!(re || we) ? 1'b1 : arm_q);

  component_register #(.WIDTH(1), .RESET_VAL(1'b1)) u_arm (
    .clk(clk), .rst_n(rst), .en(1'b1), .d(arm_d), .q(arm_q)
  );

  component_register #(.WIDTH(WAYS + WB + 1)) u_latch (
    .clk(clk), .rst_n(rst), .en(accept), .d({victim_way, word_off, we}), .q(lat_q)
  );

  assign victim_q = lat_q[WAYS+WB:WB+1];
  assign off_q    = lat_q[WB:1];
  assign op_q     = cws_op_t'(lat_q[0]);

  component_counter #(.WIDTH(WW)) u_wait_cnt (
    .clk(clk), .rst_n(rst), .load(state_q != WAIT), .load_val('0),
    .en(state_q == WAIT), .count(wait_cnt)
  );

  component_counter #(.WIDTH(WB)) u_fill_cnt (
    .clk(clk), .rst_n(rst), .load(state_q != FILL), .load_val('0),
    .en(state_q == FILL), .count(fill_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    cache_we = '0;
    word_sel = '0;
    fill_src = 1'b0;
    mem_re   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Hits and non-allocating write misses finish without leaving IDLE.
          if (hit || (we && WRITE_ALLOC == 0)) done_d = 1'b1;
          else state_d = (MEM_LATENCY == 0) ? FILL : WAIT;
          if (we && hit) begin
            cache_we = hit_way;
            word_sel = word_off;
          end
        end
      end
      WAIT: begin
        mem_re = (wait_cnt == '0);
        if (wait_cnt == WAIT_LAST) state_d = FILL;
      end
      FILL: begin
        cache_we = victim_q;
        fill_src = 1'b1;
        word_sel = fill_cnt;
        mem_re   = (MEM_LATENCY == 0) && (fill_cnt == '0);
        if (fill_cnt == FILL_LAST) state_d = (op_q == OP_WR) ? MERGE : DONE;
      end
      MERGE: begin
        cache_we = victim_q;
        word_sel = off_q;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q || (state_q == DONE);

endmodule
`default_nettype wire
